dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Data-memory access controller between the MEM stage and the SRAM-like data bus. It consumes the MEM stage's address, byte strobe, aligned store data, size and exception type, and issues one bus transaction per load/store. It maps kseg0/kseg1 addresses to physical addresses and returns read data to MEM's `mem_rdata` input. It stalls the pipeline until the transaction completes and drains in-flight transactions after a flush.

## Interface
- No parameters.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- mem_valid  in  1  MEM stage holds a valid instruction
- mem_rmem  in  1  instruction is a load
- mem_wmem  in  1  instruction is a store
- mem_aluout  in  32  virtual address
- sel  in  4  byte strobe from memsel
- mem_wdata_last  in  32  lane-aligned store data
- mem_size  in  2  0=byte, 1=half, 2=word
- mem_excepttype  in  32  nonzero = exception pending in MEM
- kseg0_uncached  in  1  kseg0 treated as uncached
- flush  in  1  exception/eret flush of MEM stage
- stall_other  in  1  pipeline held by another source
- data_req  out  1  bus request
- data_wr  out  1  1=write
- data_size  out  2  transfer size
- data_addr  out  32  physical address
- data_wstrb  out  4  write byte strobe, 0 on reads
- data_wdata  out  32  write data
- data_uncached  out  1  uncached attribute
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid / write done
- data_rdata  in  32  read data
- mem_rdata  out  32  load data to MEM stage
- mem_stall  out  1  hold IF..MEM

## Operation
- Access condition: `start = IDLE & mem_valid & (mem_rmem | mem_wmem) & (mem_excepttype == 0) & ~flush`.
- Address mapping: if va[31:30]==2'b10 (kseg0/kseg1), `data_addr = {3'b000, va[28:0]}`; otherwise va passes through unchanged.
- Uncached: `data_uncached = (va[31:29]==3'b101) | (va[31:29]==3'b100 & kseg0_uncached)`.
- States: IDLE, ADDR, DATA, DONE, CANCEL.
- IDLE
  - On `start`, drive `data_req=1` combinationally from the live inputs and latch all request fields.
  - `addr_ok` -> DATA; else -> ADDR.
- ADDR
  - Drive `data_req=1` from the latched fields.
  - `addr_ok & ~flush` -> DATA.
  - `addr_ok & flush` -> CANCEL.
  - `~addr_ok & flush` -> IDLE, and `data_req` drops in the next cycle. Withdrawing before acceptance is legal.
  - Otherwise stay in ADDR.
- DATA
  - `data_ok & flush` -> IDLE.
  - `data_ok & stall_other` -> DONE, capturing `data_rdata` into `rdata_q`.
  - `data_ok` -> IDLE, capturing `rdata_q`.
  - `flush` -> CANCEL.
  - Otherwise stay in DATA.
- DONE
  - Holds the result while the pipeline is frozen.
  - `~stall_other | flush` -> IDLE. No new request is issued for the same instruction.
- CANCEL
  - Wait for `data_ok`, discard the data, -> IDLE.
- mem_stall = `(IDLE & start & ~addr_ok)` | `(IDLE & start & addr_ok)` | ADDR | `(DATA & ~data_ok)` | CANCEL.
  - `mem_stall` is 0 in DONE and in the DATA cycle in which `data_ok` is asserted.
- mem_rdata = `data_rdata` when `DATA & data_ok`; otherwise `rdata_q`.
- Write transactions:
  - `data_wstrb = sel` and `data_wdata = mem_wdata_last`.
  - `data_ok` completes the write; `rdata_q` is still captured but is ignored by MEM.
- Bus rules:
  - `data_ok` is evaluated only in DATA and CANCEL.
  - The slave never asserts `data_ok` in the same cycle as `addr_ok` for the same transaction.
  - At most one transaction is outstanding.

## Timing
- Reset values (async, rst=0): state=IDLE, latched fields=0, rdata_q=0.
  - Outputs at reset: data_req=0, data_wr=0, data_size=0, data_addr=0, data_wstrb=0, data_wdata=0, data_uncached=0, mem_rdata=0, mem_stall=0.
- Best-case load latency: request in cycle 0 with `addr_ok`, `data_ok` in cycle 1.
  - `mem_stall` is high in cycle 0 and low in cycle 1.
  - `mem_rdata` is valid combinationally in cycle 1.
- Each cycle of `addr_ok` or `data_ok` delay adds one stall cycle.
- Flush during CANCEL has no effect; CANCEL always waits for its `data_ok`.
- Reset mid-transaction returns to IDLE immediately. The bus is reset together with the core.
- An exception in MEM (`mem_excepttype != 0`) or `flush` in IDLE: `data_req` stays 0 and `mem_stall` stays 0.

## Test plan
- Word load, va 0x8000_1004, `addr_ok` in cycle 0, `data_ok` + rdata 0xDEADBEEF in cycle 2 -> data_addr 0x0000_1004, data_uncached=0, mem_stall high for cycles 0-1, mem_rdata 0xDEADBEEF in cycle 2.
- Byte store, va 0xA000_0003, sel 4'b1000, wdata 0x5A00_0000 -> data_wr=1, data_size=0, data_wstrb 4'b1000, data_uncached=1, addr 0x0000_0003.
- Load with mem_excepttype 0x4 (AdEL) -> no data_req, mem_stall=0.
- Flush while in DATA, `data_ok` arrives 3 cycles later with rdata 0x1234 -> state goes to CANCEL, mem_stall high until that `data_ok`, data discarded, mem_rdata unchanged, back to IDLE.
- `data_ok` with stall_other=1 for 2 cycles -> DONE holds mem_rdata, no second data_req, IDLE after stall_other falls.
- Reset asserted while in ADDR -> all outputs 0 on the same cycle (asynchronous).

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: SRAM-like data bus between the access controller
// (master) and the data memory / bus bridge (slave).
//   data_req/data_wr/data_size/data_addr/data_wstrb/data_wdata/data_uncached
//     request fields, master -> slave
//   data_addr_ok  request accepted, slave -> master
//   data_data_ok  read data valid / write done, slave -> master
//   data_rdata    read data, slave -> master
interface dmem_access_ctrl_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_uncached;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
           data_uncached,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
           data_uncached,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: data-memory access controller between the MEM stage and
// the SRAM-like data bus. Issues one bus transaction per load/store, maps
// kseg0/kseg1 to physical addresses, returns load data, stalls the pipeline
// until completion and drains an accepted transaction after a flush.
//   clk, rst (async, active-low)
//   mem_*            MEM-stage request (valid, load/store, va, strobe, data,
//                    size, exception type)
//   kseg0_uncached   treat kseg0 as uncached
//   flush            exception/eret flush of MEM
//   stall_other      pipeline held by another source
//   bus              data bus master port
//   mem_rdata        load data to MEM
//   mem_stall        hold IF..MEM
module dmem_access_ctrl (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_valid,
  input  logic                       mem_rmem,
  input  logic                       mem_wmem,
  input  logic [31:0]                mem_aluout,
  input  logic [3:0]                 sel,
  input  logic [31:0]                mem_wdata_last,
  input  logic [1:0]                 mem_size,
  input  logic [31:0]                mem_excepttype,
  input  logic                       kseg0_uncached,
  input  logic                       flush,
  input  logic                       stall_other,
  dmem_access_ctrl_if.master         bus,
  output logic [31:0]                mem_rdata,
  output logic                       mem_stall
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    DONE,
    CANCEL
  } state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        unc_q, unc_d;
  logic [31:0] rdata_q, rdata_d;

  logic        start;
  logic [31:0] live_addr;
  logic        live_unc;
  logic [3:0]  live_wstrb;

  always_comb begin
    live_addr  = (mem_aluout[31:30] == 2'b10) ? {3'b000, mem_aluout[28:0]}
                                              : mem_aluout;
    live_unc   = (mem_aluout[31:29] == 3'b101) |
                 ((mem_aluout[31:29] == 3'b100) & kseg0_uncached);
    live_wstrb = mem_wmem ? sel : '0;
    // rst gates start so every output is quiet for the whole reset window,
    // even if MEM still presents the interrupted request.
    start      = rst & (state_q == IDLE) & mem_valid & (mem_rmem | mem_wmem) &
                 (mem_excepttype == '0) & ~flush;
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    unc_d   = unc_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          wr_d    = mem_wmem;
          size_d  = mem_size;
          addr_d  = live_addr;
          wstrb_d = live_wstrb;
          wdata_d = mem_wdata_last;
          unc_d   = live_unc;
          state_d = bus.data_addr_ok ? DATA : ADDR;
        end
      end
      ADDR: begin
        if (bus.data_addr_ok)   state_d = flush ? CANCEL : DATA;
        else if (flush)         state_d = IDLE;
      end
      DATA: begin
        if (bus.data_data_ok) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            rdata_d = bus.data_rdata;
            state_d = stall_other ? DONE : IDLE;
          end
        end else if (flush) begin
          state_d = CANCEL;
        end
      end
      DONE: begin
        if (~stall_other | flush) state_d = IDLE;
      end
      CANCEL: begin
        if (bus.data_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      unc_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      unc_q   <= unc_d;
      rdata_q <= rdata_d;
    end
  end

  // The first request cycle comes straight from MEM so a load accepted at
  // once costs a single stall cycle; later cycles use the latched copy.
  assign bus.data_req      = start | (state_q == ADDR);
  assign bus.data_wr       = start ? mem_wmem       : wr_q;
  assign bus.data_size     = start ? mem_size       : size_q;
  assign bus.data_addr     = start ? live_addr      : addr_q;
  assign bus.data_wstrb    = start ? live_wstrb     : wstrb_q;
  assign bus.data_wdata    = start ? mem_wdata_last : wdata_q;
  assign bus.data_uncached = start ? live_unc       : unc_q;

  assign mem_stall = start | (state_q == ADDR) |
                     ((state_q == DATA) & ~bus.data_data_ok) |
                     (state_q == CANCEL);

  assign mem_rdata = ((state_q == DATA) & bus.data_data_ok) ? bus.data_rdata
                                                            : rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid, mem_rmem, mem_wmem;
  logic [31:0] mem_aluout, mem_wdata_last, mem_excepttype;
  logic [3:0]  sel;
  logic [1:0]  mem_size;
  logic        kseg0_uncached, flush, stall_other;
  logic [31:0] mem_rdata;
  logic        mem_stall;

  dmem_access_ctrl_if bus ();

  dmem_access_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_rmem       (mem_rmem),
    .mem_wmem       (mem_wmem),
    .mem_aluout     (mem_aluout),
    .sel            (sel),
    .mem_wdata_last (mem_wdata_last),
    .mem_size       (mem_size),
    .mem_excepttype (mem_excepttype),
    .kseg0_uncached (kseg0_uncached),
    .flush          (flush),
    .stall_other    (stall_other),
    .bus            (bus),
    .mem_rdata      (mem_rdata),
    .mem_stall      (mem_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        unc;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        stall;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned req_cycles = 0;
  logic [31:0] exp_rdq = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on each accepted request and each data_ok.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.data_req) req_cycles++;
      if (bus.data_req && bus.data_addr_ok) begin
        if (req_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_req: addr 0x%08h with empty queue", bus.data_addr);
        end else begin
          req_t e;
          e = req_q.pop_front();
          chk("req_wr",    {31'b0, bus.data_wr},       {31'b0, e.wr});
          chk("req_size",  {30'b0, bus.data_size},     {30'b0, e.size});
          chk("req_addr",  bus.data_addr,              e.addr);
          chk("req_wstrb", {28'b0, bus.data_wstrb},    {28'b0, e.wstrb});
          chk("req_wdata", bus.data_wdata,             e.wdata);
          chk("req_unc",   {31'b0, bus.data_uncached}, {31'b0, e.unc});
        end
      end
      if (bus.data_data_ok) begin
        if (rsp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_data_ok: mem_rdata 0x%08h with empty queue", mem_rdata);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk("rsp_rdata", mem_rdata,         r.rdata);
          chk("rsp_stall", {31'b0, mem_stall}, {31'b0, r.stall});
        end
      end
    end
  end

  task automatic nc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    mem_valid = 0; mem_rmem = 0; mem_wmem = 0;
    mem_aluout = '0; sel = '0; mem_wdata_last = '0; mem_size = '0;
    mem_excepttype = '0; kseg0_uncached = 0; flush = 0; stall_other = 0;
    bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata = '0;
  endtask

  task automatic set_load(input logic [31:0] va);
    mem_valid = 1; mem_rmem = 1; mem_wmem = 0; mem_aluout = va;
    sel = 4'hf; mem_size = 2'd2; mem_wdata_last = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"},   {31'b0, bus.data_req},      0);
    chk({tag, "_wr"},    {31'b0, bus.data_wr},       0);
    chk({tag, "_size"},  {30'b0, bus.data_size},     0);
    chk({tag, "_addr"},  bus.data_addr,              0);
    chk({tag, "_wstrb"}, {28'b0, bus.data_wstrb},    0);
    chk({tag, "_wdata"}, bus.data_wdata,             0);
    chk({tag, "_unc"},   {31'b0, bus.data_uncached}, 0);
    chk({tag, "_rdata"}, mem_rdata,                  0);
    chk({tag, "_stall"}, {31'b0, mem_stall},         0);
  endtask

  // Best-case load: accepted in cycle 0, data in cycle 1.
  task automatic do_load(input logic [31:0] va, input logic kunc,
                         input logic [31:0] exp_addr, input logic exp_unc,
                         input logic [31:0] rd);
    set_load(va);
    kseg0_uncached = kunc;
    bus.data_addr_ok = 1;
    req_q.push_back('{1'b0, 2'd2, exp_addr, 4'h0, 32'h0, exp_unc});
    @(negedge clk);
    chk("ld_stall_c0", {31'b0, mem_stall}, 1);
    nc;
    bus.data_addr_ok = 0; bus.data_data_ok = 1; bus.data_rdata = rd;
    rsp_q.push_back('{rd, 1'b0});
    @(negedge clk);
    chk("ld_req_c1", {31'b0, bus.data_req}, 0);
    nc;
    bus.data_data_ok = 0; mem_valid = 0; mem_rmem = 0;
    exp_rdq = rd;
    @(negedge clk);
    chk("ld_rdq_hold", mem_rdata, exp_rdq);
    chk("ld_stall_idle", {31'b0, mem_stall}, 0);
    nc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned rc0;
    idle_inputs();
    #2;
    check_all_zero("reset");
    nc; nc;
    rst = 1;
    nc;

    // Word load through kseg0, addr_ok at once, data_ok two cycles later.
    set_load(32'h8000_1004);
    bus.data_addr_ok = 1;
    req_q.push_back('{1'b0, 2'd2, 32'h0000_1004, 4'h0, 32'h0, 1'b0});
    @(negedge clk);
    chk("t1_stall_c0", {31'b0, mem_stall}, 1);
    nc;
    bus.data_addr_ok = 0;
    @(negedge clk);
    chk("t1_stall_c1", {31'b0, mem_stall}, 1);
    chk("t1_req_c1", {31'b0, bus.data_req}, 0);
    nc;
    bus.data_data_ok = 1; bus.data_rdata = 32'hDEAD_BEEF;
    rsp_q.push_back('{32'hDEAD_BEEF, 1'b0});
    nc;
    bus.data_data_ok = 0; mem_valid = 0; mem_rmem = 0;
    exp_rdq = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t1_rdq", mem_rdata, exp_rdq);
    nc;

    // Byte store through kseg1, addr_ok one cycle late, MEM inputs changed
    // while waiting so the latched copy is what gets accepted.
    mem_valid = 1; mem_wmem = 1; mem_aluout = 32'hA000_0003; sel = 4'b1000;
    mem_wdata_last = 32'h5A00_0000; mem_size = 2'd0;
    req_q.push_back('{1'b1, 2'd0, 32'h0000_0003, 4'b1000, 32'h5A00_0000, 1'b1});
    @(negedge clk);
    chk("t2_req_c0", {31'b0, bus.data_req}, 1);
    chk("t2_stall_c0", {31'b0, mem_stall}, 1);
    nc;
    mem_aluout = 32'h1234_5678; sel = 4'h0; mem_wdata_last = 32'hFFFF_FFFF;
    mem_size = 2'd2; bus.data_addr_ok = 1;
    @(negedge clk);
    chk("t2_stall_c1", {31'b0, mem_stall}, 1);
    nc;
    bus.data_addr_ok = 0; bus.data_data_ok = 1; bus.data_rdata = 32'h0000_0077;
    rsp_q.push_back('{32'h0000_0077, 1'b0});
    nc;
    bus.data_data_ok = 0; mem_valid = 0; mem_wmem = 0;
    exp_rdq = 32'h0000_0077;
    @(negedge clk);
    chk("t2_rdq", mem_rdata, exp_rdq);
    nc;

    // Address map / uncached corners.
    do_load(32'h0040_0010, 1'b0, 32'h0040_0010, 1'b0, 32'h1111_1111);
    do_load(32'h8000_0020, 1'b1, 32'h0000_0020, 1'b1, 32'h2222_2222);
    do_load(32'hC000_0040, 1'b1, 32'hC000_0040, 1'b0, 32'h3333_3333);

    // Exception pending, then flush in IDLE: no request, no stall.
    set_load(32'h8000_0001);
    mem_excepttype = 32'h4; bus.data_addr_ok = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t3_exc_req", {31'b0, bus.data_req}, 0);
      chk("t3_exc_stall", {31'b0, mem_stall}, 0);
      nc;
    end
    mem_excepttype = '0; flush = 1;
    @(negedge clk);
    chk("t3_flush_req", {31'b0, bus.data_req}, 0);
    chk("t3_flush_stall", {31'b0, mem_stall}, 0);
    nc;
    idle_inputs();
    nc;

    // Flush in DATA -> CANCEL, data_ok 3 cycles later is discarded.
    set_load(32'h8000_2000);
    bus.data_addr_ok = 1;
    req_q.push_back('{1'b0, 2'd2, 32'h0000_2000, 4'h0, 32'h0, 1'b0});
    nc;
    bus.data_addr_ok = 0; flush = 1;
    @(negedge clk);
    chk("t4_stall_flush", {31'b0, mem_stall}, 1);
    nc;
    mem_valid = 0; mem_rmem = 0;
    @(negedge clk);
    chk("t4_stall_cancel1", {31'b0, mem_stall}, 1);
    chk("t4_req_cancel1", {31'b0, bus.data_req}, 0);
    nc;
    flush = 0;
    @(negedge clk);
    chk("t4_stall_cancel2", {31'b0, mem_stall}, 1);
    nc;
    bus.data_data_ok = 1; bus.data_rdata = 32'h0000_1234;
    rsp_q.push_back('{exp_rdq, 1'b1});
    nc;
    bus.data_data_ok = 0;
    @(negedge clk);
    chk("t4_stall_after", {31'b0, mem_stall}, 0);
    chk("t4_rdq_kept", mem_rdata, exp_rdq);
    nc;

    // data_ok under stall_other -> DONE holds data, no second request.
    rc0 = req_cycles;
    set_load(32'h9FC0_0100);
    bus.data_addr_ok = 1;
    req_q.push_back('{1'b0, 2'd2, 32'h1FC0_0100, 4'h0, 32'h0, 1'b0});
    nc;
    bus.data_addr_ok = 0; bus.data_data_ok = 1; stall_other = 1;
    bus.data_rdata = 32'hCAFE_F00D;
    rsp_q.push_back('{32'hCAFE_F00D, 1'b0});
    nc;
    bus.data_data_ok = 0; bus.data_rdata = 32'hBAD0_BAD0;
    exp_rdq = 32'hCAFE_F00D;
    @(negedge clk);
    chk("t5_done_rdata", mem_rdata, exp_rdq);
    chk("t5_done_stall", {31'b0, mem_stall}, 0);
    chk("t5_done_req", {31'b0, bus.data_req}, 0);
    nc;
    stall_other = 0;
    @(negedge clk);
    chk("t5_done2_rdata", mem_rdata, exp_rdq);
    chk("t5_done2_req", {31'b0, bus.data_req}, 0);
    nc;
    mem_valid = 0; mem_rmem = 0;
    @(negedge clk);
    chk("t5_idle_rdata", mem_rdata, exp_rdq);
    chk("t5_req_cycles", req_cycles - rc0, 1);
    nc;

    // Asynchronous reset while waiting in ADDR.
    set_load(32'hBFC0_0000);
    nc;
    @(negedge clk);
    chk("t6_addr_req", {31'b0, bus.data_req}, 1);
    chk("t6_addr_addr", bus.data_addr, 32'h1FC0_0000);
    #1 rst = 0;
    #1;
    check_all_zero("t6_rst");
    nc;
    idle_inputs();
    rst = 1;
    @(negedge clk);
    chk("t6_post_rdata", mem_rdata, 0);
    chk("t6_post_stall", {31'b0, mem_stall}, 0);
    nc; nc;

    chk("req_q_empty", req_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
